// File: rtl/swap_cmd_queue.sv
// Command stage ahead of the memory swapper: queues swap requests and
// arbitrates them fairly against host single-word writes.
module swap_cmd_queue #(
    parameter int addr_w_N    = 7,
    parameter int data_w_Bits = 8,
    parameter int DEPTH       = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [addr_w_N-1:0]       req_addr_A,
    input  logic [addr_w_N-1:0]       req_addr_B,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [addr_w_N-1:0]       wr_addr,
    input  logic [data_w_Bits-1:0]    wr_data,
    output logic                      swap,
    output logic [addr_w_N-1:0]       address_A,
    output logic [addr_w_N-1:0]       address_B,
    output logic                      we,
    output logic [addr_w_N-1:0]       address_w,
    output logic [data_w_Bits-1:0]    data_w,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(SWAP_CYCLES + 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t              state;
    logic [TW-1:0]       cnt;
    logic                last_was_write;
    logic [addr_w_N-1:0] mem_a [DEPTH];
    logic [addr_w_N-1:0] mem_b [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    logic idle;
    logic full;
    logic push;
    logic grant_swap;
    logic grant_wr;

    assign idle      = (state == IDLE);
    assign full      = (count == CW'(DEPTH));
    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign wr_ready  = idle && (count == '0 || !last_was_write);
    // A queued swap yields to a write only if the previous grant was a swap.
    assign grant_swap = idle && (count != '0) && (last_was_write || !wr_valid);
    assign grant_wr   = wr_valid && wr_ready;
    assign busy       = !idle || (count != '0) || we;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= req_addr_A;
            mem_b[wr_ptr] <= req_addr_B;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (grant_swap) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, grant_swap})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            last_was_write <= 1'b0;
            swap           <= 1'b0;
            address_A      <= '0;
            address_B      <= '0;
            we             <= 1'b0;
            address_w      <= '0;
            data_w         <= '0;
        end else begin
            swap <= grant_swap;
            we   <= grant_wr;
            if (grant_wr) begin
                address_w      <= wr_addr;
                data_w         <= wr_data;
                last_was_write <= 1'b1;
            end
            if (grant_swap) begin
                address_A      <= mem_a[rd_ptr];
                address_B      <= mem_b[rd_ptr];
                state          <= HOLD;
                cnt            <= TW'(SWAP_CYCLES - 1);
                last_was_write <= 1'b0;
            end else if (state == HOLD) begin
                // Addresses stay put until the swapper has finished.
                if (cnt == '0) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_swap_cmd_queue.sv
// Bench for swap_cmd_queue: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model.
module tb_swap_cmd_queue;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SC    = 3;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [AW-1:0]         req_addr_A = '0;
    logic [AW-1:0]         req_addr_B = '0;
    logic                  wr_valid = 1'b0;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr = '0;
    logic [DW-1:0]         wr_data = '0;
    logic                  swap;
    logic [AW-1:0]         address_A;
    logic [AW-1:0]         address_B;
    logic                  we;
    logic [AW-1:0]         address_w;
    logic [DW-1:0]         data_w;
    logic [$clog2(DEPTH):0] count;
    logic                  busy;

    always #5 clk = ~clk;

    swap_cmd_queue #(
        .addr_w_N(AW),
        .data_w_Bits(DW),
        .DEPTH(DEPTH),
        .SWAP_CYCLES(SC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr_A(req_addr_A),
        .req_addr_B(req_addr_B),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .swap(swap),
        .address_A(address_A),
        .address_B(address_B),
        .we(we),
        .address_w(address_w),
        .data_w(data_w),
        .count(count),
        .busy(busy)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } pair_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: pending requests, remaining swap-window cycles,
    // who won the last grant, and the registered outputs.
    pair_t         mq[$];
    int            hold_left;
    bit            lww;
    bit            m_swap;
    bit            m_we;
    logic [AW-1:0] m_aA;
    logic [AW-1:0] m_aB;
    logic [AW-1:0] m_aw;
    logic [DW-1:0] m_dw;

    pair_t swap_log[$];
    int    swap_time[$];
    string ev_log;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        hold_left = 0;
        lww       = 1'b0;
        m_swap    = 1'b0;
        m_we      = 1'b0;
        m_aA      = '0;
        m_aB      = '0;
        m_aw      = '0;
        m_dw      = '0;
    endtask

    task automatic check_outputs();
        chk("swap", 32'(swap), 32'(m_swap));
        chk("address_A", 32'(address_A), 32'(m_aA));
        chk("address_B", 32'(address_B), 32'(m_aB));
        chk("we", 32'(we), 32'(m_we));
        chk("address_w", 32'(address_w), 32'(m_aw));
        chk("data_w", 32'(data_w), 32'(m_dw));
        chk("count", 32'(count), 32'(mq.size()));
        chk("busy", 32'(busy),
            32'(hold_left != 0 || mq.size() != 0 || m_we));
        chk("req_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
        chk("wr_ready", 32'(wr_ready),
            32'(hold_left == 0 && (mq.size() == 0 || !lww)));
    endtask

    task automatic cycle(input bit rv, input int a, input int b,
                         input bit wv, input int wa, input int wd);
        bit    idle_m;
        bit    rqr;
        bit    wrr;
        bit    gw;
        bit    gs;
        pair_t head;
        req_valid  = rv;
        req_addr_A = AW'(a);
        req_addr_B = AW'(b);
        wr_valid   = wv;
        wr_addr    = AW'(wa);
        wr_data    = DW'(wd);
        idle_m = (hold_left == 0);
        rqr    = (mq.size() < DEPTH);
        wrr    = idle_m && (mq.size() == 0 || !lww);
        gw     = wv && wrr;
        gs     = idle_m && mq.size() != 0 && (lww || !wv);
        @(posedge clk);
        #1;
        cyc++;
        m_swap = gs;
        m_we   = gw;
        if (gs) begin
            head      = mq.pop_front();
            m_aA      = head.a;
            m_aB      = head.b;
            hold_left = SC;
            lww       = 1'b0;
        end else if (hold_left > 0) begin
            hold_left--;
        end
        if (gw) begin
            m_aw = AW'(wa);
            m_dw = DW'(wd);
            lww  = 1'b1;
        end
        if (rv && rqr) begin
            mq.push_back({AW'(a), AW'(b)});
        end
        check_outputs();
        if (swap) begin
            swap_log.push_back({address_A, address_B});
            swap_time.push_back(cyc);
            ev_log = {ev_log, "S"};
        end
        if (we) begin
            ev_log = {ev_log, "W"};
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 0, 0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        int    t0;
        pair_t exp_order[6];

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.swap", 32'(swap), 0);
        chk("rst.we", 32'(we), 0);
        chk("rst.address_A", 32'(address_A), 0);
        chk("rst.address_B", 32'(address_B), 0);
        chk("rst.address_w", 32'(address_w), 0);
        chk("rst.data_w", 32'(data_w), 0);
        chk("rst.count", 32'(count), 0);
        chk("rst.busy", 32'(busy), 0);
        reset_n = 1'b1;
        #1;
        chk("rel.req_ready", 32'(req_ready), 1);
        chk("rel.wr_ready", 32'(wr_ready), 1);
        chk("rel.busy", 32'(busy), 0);

        cycle(1'b0, 0, 0, 1'b1, 5, 8'hA5);
        chk("wr1.we", 32'(we), 1);
        chk("wr1.address_w", 32'(address_w), 5);
        chk("wr1.data_w", 32'(data_w), 32'hA5);
        idle_cycles(1);
        chk("wr1.we_drop", 32'(we), 0);

        swap_log.delete();
        swap_time.delete();
        t0 = cyc;
        cycle(1'b1, 3, 9, 1'b0, 0, 0);
        cycle(1'b1, 10, 11, 1'b0, 0, 0);
        chk("sw1.pulse", 32'(swap), 1);
        for (int i = 0; i < 3; i++) begin
            chk("sw1.addr_A_stable", 32'(address_A), 3);
            chk("sw1.addr_B_stable", 32'(address_B), 9);
            chk("sw1.we_low", 32'(we), 0);
            idle_cycles(1);
        end
        idle_cycles(6);
        chk("sw1.pulses", 32'(swap_time.size()), 2);
        if (swap_time.size() == 2) begin
            chk("sw1.latency", 32'(swap_time[0] - t0), 2);
            chk("sw1.spacing", 32'(swap_time[1] - swap_time[0]), SC + 1);
            chk("sw1.second", 32'(swap_log[1]), 32'({7'd10, 7'd11}));
        end

        swap_log.delete();
        cycle(1'b1, 1, 2, 1'b0, 0, 0);
        cycle(1'b1, 20, 21, 1'b0, 0, 0);
        cycle(1'b1, 22, 23, 1'b0, 0, 0);
        cycle(1'b1, 24, 25, 1'b0, 0, 0);
        cycle(1'b1, 26, 27, 1'b0, 0, 0);
        chk("fill.count", 32'(count), 4);
        chk("fill.req_ready", 32'(req_ready), 0);
        cycle(1'b1, 30, 31, 1'b0, 0, 0);
        chk("fill.held_off", 32'(count), 3);
        cycle(1'b1, 30, 31, 1'b0, 0, 0);
        idle_cycles(25);
        exp_order[0] = {7'd1, 7'd2};
        exp_order[1] = {7'd20, 7'd21};
        exp_order[2] = {7'd22, 7'd23};
        exp_order[3] = {7'd24, 7'd25};
        exp_order[4] = {7'd26, 7'd27};
        exp_order[5] = {7'd30, 7'd31};
        chk("fill.n_swaps", 32'(swap_log.size()), 6);
        for (int i = 0; i < 6 && i < swap_log.size(); i++) begin
            chk("fill.order", 32'(swap_log[i]), 32'(exp_order[i]));
        end

        swap_log.delete();
        cycle(1'b1, 50, 51, 1'b0, 0, 0);
        cycle(1'b1, 52, 53, 1'b0, 0, 0);
        cycle(1'b1, 54, 55, 1'b0, 0, 0);
        idle_cycles(2);
        chk("pp.count_before", 32'(count), 2);
        cycle(1'b1, 7, 7, 1'b0, 0, 0);
        chk("pp.count_same", 32'(count), 2);
        idle_cycles(20);
        chk("pp.n_swaps", 32'(swap_log.size()), 4);
        if (swap_log.size() == 4) begin
            chk("pp.a_eq_b", 32'(swap_log[3]), 32'({7'd7, 7'd7}));
        end

        ev_log = "";
        cycle(1'b1, 60, 61, 1'b0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            cycle(i == 1, 62, 63, 1'b1, 40 + i, i);
            if (i >= 2 && i <= 4) begin
                chk("cont.wr_ready_hold", 32'(wr_ready), 0);
            end
        end
        idle_cycles(6);
        checks++;
        assert (ev_log == "WSWS") else begin
            errors++;
            $error("FAIL cont.order observed=%s expected=WSWS", ev_log);
        end

        cycle(1'b1, 70, 71, 1'b0, 0, 0);
        cycle(1'b1, 72, 73, 1'b0, 0, 0);
        cycle(1'b1, 74, 75, 1'b0, 0, 0);
        chk("rmid.count_pre", 32'(count), 2);
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmid.swap", 32'(swap), 0);
        chk("rmid.we", 32'(we), 0);
        chk("rmid.count", 32'(count), 0);
        chk("rmid.busy", 32'(busy), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        swap_log.delete();
        idle_cycles(10);
        chk("rmid.no_swaps", 32'(swap_log.size()), 0);

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) == 0, int'($urandom_range(0, 127)),
                  int'($urandom_range(0, 127)), $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
        end
        idle_cycles(30);
        chk("end.count", 32'(count), 0);
        chk("end.busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
